// File: rtl/uart_tx_arbiter.sv
// Round-robin, line-locked arbiter sharing one UART transmit line between NUM_REQ byte streams.
// Define UART_TX_ARB_PARITY_EN to insert an even parity bit after data bit 7 (11-bit frames).
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLK_DIV      = 16,
    parameter int MAX_LINE     = 255,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*8-1:0]       req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       tx_o,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       locked_o
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int SW = OW + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

`ifdef UART_TX_ARB_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          state_reg, state_next;
    logic [DW-1:0]   div_reg, div_next;
    logic [2:0]      bit_reg, bit_next;
    logic [7:0]      data_reg, data_next;
    logic            tx_reg, tx_next;
    logic [OW-1:0]   owner_reg, owner_next;
    logic            locked_reg, locked_next;
    logic [OW-1:0]   rr_reg, rr_next;
    logic [7:0]      line_reg, line_next;
    logic [TW-1:0]   to_reg, to_next;

    logic [2*NUM_REQ-2:0] dbl_valid;
    logic [NUM_REQ-1:0]   rot_valid;
    logic                 scan_hit;
    logic [OW-1:0]        scan_off;
    logic [SW-1:0]        scan_sum;
    logic [OW-1:0]        scan_idx;
    logic [OW-1:0]        grant_idx;
    logic                 grant_valid;
    logic [7:0]           grant_byte;
    logic                 handshake;

    function automatic logic [OW-1:0] inc_wrap(input logic [OW-1:0] v);
        return (v == OW'(NUM_REQ - 1)) ? '0 : v + 1'b1;
    endfunction

    // Rotate the valid vector so bit 0 is the requester at the rr pointer.
    assign dbl_valid = {req_valid_i[NUM_REQ-2:0], req_valid_i};
    assign rot_valid = dbl_valid[rr_reg +: NUM_REQ];

    always_comb begin
        scan_hit = 1'b0;
        scan_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                scan_hit = 1'b1;
                scan_off = OW'(k);
            end
        end
        scan_sum = {1'b0, rr_reg} + {1'b0, scan_off};
        scan_idx = (scan_sum >= SW'(NUM_REQ)) ? OW'(scan_sum - SW'(NUM_REQ)) : OW'(scan_sum);
    end

    assign grant_idx   = locked_reg ? owner_reg : scan_idx;
    assign grant_valid = locked_reg ? req_valid_i[owner_reg] : scan_hit;
    assign grant_byte  = req_data_i[{grant_idx, 3'b000} +: 8];
    assign handshake   = rst_ni && (state_reg == S_IDLE) && grant_valid;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready_o[gi] = handshake && (grant_idx == OW'(gi));
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        div_next    = div_reg;
        bit_next    = bit_reg;
        data_next   = data_reg;
        tx_next     = tx_reg;
        owner_next  = owner_reg;
        locked_next = locked_reg;
        rr_next     = rr_reg;
        line_next   = line_reg;
        to_next     = to_reg;

        if (state_reg == S_IDLE) begin
            tx_next = 1'b1;
            if (handshake) begin
                data_next  = grant_byte;
                owner_next = grant_idx;
                state_next = S_START;
                div_next   = DW'(CLK_DIV - 1);
                bit_next   = 3'd0;
                tx_next    = 1'b0;
                to_next    = '0;
                if (grant_byte == 8'h0A || ({1'b0, line_reg} + 9'd1 == 9'(MAX_LINE))) begin
                    locked_next = 1'b0;
                    line_next   = 8'd0;
                    rr_next     = inc_wrap(grant_idx);
                end else begin
                    locked_next = 1'b1;
                    line_next   = line_reg + 8'd1;
                end
            end else if (locked_reg) begin
                // Fires on the idle cycle that brings the count up to LOCK_TIMEOUT.
                if (to_reg == TW'(LOCK_TIMEOUT - 1)) begin
                    locked_next = 1'b0;
                    line_next   = 8'd0;
                    rr_next     = inc_wrap(owner_reg);
                    to_next     = '0;
                end else begin
                    to_next = to_reg + 1'b1;
                end
            end
        end else if (div_reg != '0) begin
            div_next = div_reg - 1'b1;
        end else begin
            div_next = DW'(CLK_DIV - 1);
            case (state_reg)
                S_START: begin
                    state_next = S_DATA;
                    bit_next   = 3'd0;
                    tx_next    = data_reg[0];
                end
                S_DATA: begin
                    if (bit_reg == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
                        state_next = S_PAR;
                        tx_next    = ^data_reg;
`else
                        state_next = S_STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        bit_next = bit_reg + 3'd1;
                        tx_next  = data_reg[bit_reg + 3'd1];
                    end
                end
`ifdef UART_TX_ARB_PARITY_EN
                S_PAR: begin
                    state_next = S_STOP;
                    tx_next    = 1'b1;
                end
`endif
                default: begin
                    state_next = S_IDLE;
                    tx_next    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg  <= S_IDLE;
            div_reg    <= '0;
            bit_reg    <= 3'd0;
            data_reg   <= 8'd0;
            tx_reg     <= 1'b1;
            owner_reg  <= '0;
            locked_reg <= 1'b0;
            rr_reg     <= '0;
            line_reg   <= 8'd0;
            to_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            div_reg    <= div_next;
            bit_reg    <= bit_next;
            data_reg   <= data_next;
            tx_reg     <= tx_next;
            owner_reg  <= owner_next;
            locked_reg <= locked_next;
            rr_reg     <= rr_next;
            line_reg   <= line_next;
            to_reg     <= to_next;
        end
    end

    assign tx_o     = tx_reg;
    assign busy_o   = (state_reg != S_IDLE);
    assign owner_o  = owner_reg;
    assign locked_o = locked_reg;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmit line between `NUM_REQ` byte-stream requesters (harts, debug console, boot ROM printer) in the testbench/APU console path. Arbitration is round-robin at line granularity, so lines from different requesters never interleave. The block owns the serializer (start, 8 data LSB-first, optional parity, stop) at a fixed clocks-per-bit divider. Its `tx_o` drives the same pin the UART console receiver samples.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `CLK_DIV`, default 16: clock cycles per UART bit, at least 2.
- `MAX_LINE`, default 255: bytes after which a line lock is force-released, 1..255.
- `LOCK_TIMEOUT`, default 1024: idle cycles after which a lock is released if the owner presents nothing, 1..65535.

Ports. One clock; reset is synchronous and active-low.
- `clk_i` in 1: clock.
- `rst_ni` in 1: synchronous active-low reset.
- `req_valid_i` in NUM_REQ: byte available, one bit per requester.
- `req_data_i` in NUM_REQ*8: byte of requester i at `[i*8 +: 8]`.
- `req_ready_o` out NUM_REQ: byte accepted when valid&ready.
- `tx_o` out 1: serial line, idle high.
- `busy_o` out 1: serializer not in IDLE.
- `owner_o` out $clog2(NUM_REQ): current/last grantee.
- `locked_o` out 1: line lock held by `owner_o`.

## Operation
- FSM states: IDLE, START, DATA, PAR, STOP. PAR exists only with the macro.
- Reset values: state IDLE, `tx_o`=1, `req_ready_o`=0, `busy_o`=0, `owner_o`=0, `locked_o`=0, rr pointer=0, line count=0, timeout count=0.
- Grant in IDLE:
  - If locked, the grantee is `owner_o`.
  - Otherwise the grantee is the first valid requester scanning from rr pointer upward, with wrap-around.
- `req_ready_o` is combinational. It is one-hot at the grantee only when state=IDLE and the grantee's valid=1; otherwise all zero.
- On handshake:
  - Latch the byte, set `owner_o` to the grantee, go to START.
  - If the byte is 0x0A or the line count+1 equals MAX_LINE: clear the lock, clear the line count, set rr pointer to owner+1 mod NUM_REQ.
  - Otherwise set the lock and increment the line count.
- START drives 0. DATA drives bits 0..7. PAR drives even parity (XOR of data). STOP drives 1. Each bit lasts CLK_DIV cycles via a down-counter. STOP returns to IDLE.
- Lock timeout:
  - While locked and in IDLE with the owner's valid low, the timeout counter increments.
  - When it reaches LOCK_TIMEOUT: release the lock, clear the line count, advance rr pointer to owner+1.
  - The counter clears on any handshake or whenever not locked.
- Valid from other requesters while locked: ignored, and they wait. Requesters are not required to hold data stable while not ready. Once a requester raises valid it must keep it high until ready; violations are not detected.
- Reset mid-frame: `tx_o` returns to 1 on the next edge. The partial frame is abandoned and the lock is dropped.

## Timing
- Handshake at edge T, where valid&ready are sampled high. `tx_o` goes low and `busy_o` goes high from T+1.
- Bit k (0..7) is driven from T+1+(k+1)*CLK_DIV.
- Without parity, STOP starts at T+1+9*CLK_DIV. IDLE and ready again at T+1+10*CLK_DIV, so the frame is 10*CLK_DIV cycles.
- With parity, the frame is 11*CLK_DIV cycles.
- Back-to-back bytes from the owner: the next start bit begins one cycle after IDLE is re-entered. IDLE always lasts at least 1 cycle.
- Lock release and re-grant take effect in the same IDLE cycle the new state is visible. There is no extra bubble.
- Timeout fires on the cycle the counter equals LOCK_TIMEOUT. The re-grant happens the following cycle.

## Configuration
- `UART_TX_ARB_PARITY_EN`:
  - Defined: the PAR state is present, an even parity bit is inserted after bit 7, and the frame is 11 bits.
  - Undefined: there is no PAR state, the frame is 10 bits, and no parity logic is synthesized.
- Must match the receiver's `PARITY_EN` setting.

## Test plan
- Reset (rst_ni=0 for 3 cycles), then idle → `tx_o`=1, all `req_ready_o`=0, `owner_o`=0, `locked_o`=0.
- Single byte: NUM_REQ=4, CLK_DIV=16, req 2 sends 0x41 → line shows 0, then bits 1,0,0,0,0,0,1,0, then 1. Frame is 160 cycles. `locked_o`=1 afterwards with `owner_o`=2.
- No interleave: req 0 sends "ab\n" while req 1 holds valid with 'X' → line carries a,b,0x0A then X. req 1 ready stays 0 until after 0x0A is accepted.
- Round-robin: all four requesters send single 0x0A bytes continuously → grant order 0,1,2,3,0.
- Timeout: LOCK_TIMEOUT=8, req 3 sends 'a' then drops valid, req 0 valid → lock releases after 8 idle cycles, and req 0 is granted the next cycle.
- MAX_LINE=4, req 1 streams 'z' with no newline while req 2 valid → req 2 is granted after exactly 4 bytes from req 1. With `UART_TX_ARB_PARITY_EN`, byte 0x07 has parity bit 1 and the frame is 176 cycles.
